// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit sampling, holding register with sticky rdy.
// Define UART_RX_FRAME_ERR_EN to report a zero stop bit on frame_err instead of rdy.
module uart_rx #(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frame_err
);

`ifdef UART_RX_FRAME_ERR_EN
    localparam bit FRAME_ERR_EN = 1'b1;
`else
    localparam bit FRAME_ERR_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]       LAST_BIT  = 4'd10;

    typedef enum logic {
        IDLE,
        RECEIVE
    } state_t;

    state_t           state;
    logic             rx_meta;
    logic             rx_s;
    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_cnt;
    logic [8:0]       shift_reg;
    logic             frame_err_q;
    logic             shift;

    // NOTE: synchronizer flops reset to the idle level so release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    assign shift     = (baud_cnt == '0);
    assign frame_err = FRAME_ERR_EN ? frame_err_q : 1'b0;

    // NOTE: all state uses non-blocking assignments; later assignments in this block take priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= 9'h1FF;
            rx_data     <= 8'h00;
            rdy         <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (clr_rdy) begin
                rdy         <= 1'b0;
                frame_err_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        baud_cnt    <= HALF_LOAD;
                        bit_cnt     <= '0;
                        rdy         <= 1'b0;
                        frame_err_q <= 1'b0;
                        state       <= RECEIVE;
                    end
                end

                RECEIVE: begin
                    if (shift) begin
                        shift_reg <= {rx_s, shift_reg[8:1]};
                        baud_cnt  <= FULL_LOAD;
                        bit_cnt   <= bit_cnt + 4'd1;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end

                    // Start bit has been shifted out; data sits in [7:0], stop bit in [8].
                    if (bit_cnt == LAST_BIT) begin
                        rx_data <= shift_reg[7:0];
                        if (FRAME_ERR_EN && !shift_reg[8]) begin
                            frame_err_q <= 1'b1;
                        end else begin
                            rdy <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a reduced divider: latency, data, flags, reset and overrun.
// Expectations for frame_err follow UART_RX_FRAME_ERR_EN as compiled.
module tb_uart_rx;

    localparam int B   = 16;
    localparam int H   = B / 2;
    localparam int LAT = 3 + H + 9 * B;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_line = 1'b1;
    logic       clr_rdy = 1'b0;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frame_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] cap_data[$];
    int         cap_cyc[$];
    logic       cap_rdy[$];
    logic       cap_err[$];
    int         e0_q[$];
    logic       flag_prev = 1'b0;

    uart_rx #(.BAUD_DIV(B)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (rx_line),
        .clr_rdy   (clr_rdy),
        .rx_data   (rx_data),
        .rdy       (rdy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every completion (rising rdy or frame_err) with the edge count it appeared after.
    always @(negedge clk) begin
        flag_prev <= rdy | frame_err;
        if ((rdy | frame_err) && !flag_prev) begin
            cap_data.push_back(rx_data);
            cap_cyc.push_back(cyc);
            cap_rdy.push_back(rdy);
            cap_err.push_back(frame_err);
        end
    end

    task automatic clear_caps();
        cap_data.delete();
        cap_cyc.delete();
        cap_rdy.delete();
        cap_err.delete();
        e0_q.delete();
    endtask

    // Called at a negedge with the line idle; the next posedge is E0.
    // A zero stop bit is held only past its sampling point so it cannot read as a new start.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, data, 1'b0};
        e0_q.push_back(cyc + 1);
        for (int k = 0; k < 10; k++) begin
            rx_line = bits[k];
            if (k == 9 && !stop_bit) begin
                repeat (H + 1) @(negedge clk);
                rx_line = 1'b1;
                repeat (B - H - 1) @(negedge clk);
            end else begin
                repeat (B) @(negedge clk);
            end
        end
        rx_line = 1'b1;
    endtask

    task automatic wait_caps(input int n, input int budget, input string what);
        int t;
        t = 0;
        while (cap_data.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (cap_data.size() < n) begin
            failures++;
            $display("FAIL %s: captured %0d frames, required %0d", what, cap_data.size(), n);
        end
    endtask

    task automatic check_cap(input int i, input logic [7:0] exp_data, input logic exp_rdy,
                             input logic exp_err, input string what);
        if (i >= cap_data.size()) return;
        checks++;
        if (cap_data[i] !== exp_data) begin
            failures++;
            $display("FAIL %s data[%0d]: got %02h, required %02h", what, i, cap_data[i], exp_data);
        end
        checks++;
        if (cap_rdy[i] !== exp_rdy || cap_err[i] !== exp_err) begin
            failures++;
            $display("FAIL %s flags[%0d]: rdy/err got %b/%b, required %b/%b",
                     what, i, cap_rdy[i], cap_err[i], exp_rdy, exp_err);
        end
        if (i < e0_q.size()) begin
            checks++;
            if (cap_cyc[i] !== e0_q[i] + LAT) begin
                failures++;
                $display("FAIL %s latency[%0d]: visible after edge %0d, required %0d",
                         what, i, cap_cyc[i], e0_q[i] + LAT);
            end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        rx_line = 1'b1;
        clr_rdy = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rx_data !== 8'h00 || rdy !== 1'b0 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL reset: data/rdy/err got %02h/%b/%b, required 00/0/0", rx_data, rdy, frame_err);
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (rx_data !== 8'h00 || rdy !== 1'b0 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL idle after reset: data/rdy/err got %02h/%b/%b, required 00/0/0",
                     rx_data, rdy, frame_err);
        end
    endtask

    task automatic test_single_byte();
        clear_caps();
        send_frame(8'hA5, 1'b1);
        wait_caps(1, 50, "single byte");
        check_cap(0, 8'hA5, 1'b1, 1'b0, "single byte");
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        checks++;
        if (rdy !== 1'b0 || rx_data !== 8'hA5) begin
            failures++;
            $display("FAIL clr_rdy: rdy/data got %b/%02h, required 0/a5", rdy, rx_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals[3];
        vals = '{8'h00, 8'hFF, 8'h5A};
        clear_caps();
        fork
            begin
                for (int i = 0; i < 3; i++) send_frame(vals[i], 1'b1);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    int t;
                    t = 0;
                    while (!rdy && t < 4 * B * 10) begin
                        @(negedge clk);
                        t++;
                    end
                    clr_rdy = 1'b1;
                    @(negedge clk);
                    clr_rdy = 1'b0;
                end
            end
        join
        wait_caps(3, 50, "back to back");
        for (int i = 0; i < 3; i++) check_cap(i, vals[i], 1'b1, 1'b0, "back to back");
    endtask

    task automatic test_set_clr_priority();
        int e0;
        clear_caps();
        e0 = cyc + 1;
        fork
            send_frame(8'hC3, 1'b1);
            begin
                int t;
                t = 0;
                while (cyc < e0 + LAT - 1 && t < 20 * B) begin
                    @(negedge clk);
                    t++;
                end
                clr_rdy = 1'b1;
                @(negedge clk);
                checks++;
                if (rdy !== 1'b1) begin
                    failures++;
                    $display("FAIL set priority: rdy got %b, required 1 (cyc %0d)", rdy, cyc);
                end
                @(negedge clk);
                clr_rdy = 1'b0;
                checks++;
                if (rdy !== 1'b0 || rx_data !== 8'hC3) begin
                    failures++;
                    $display("FAIL clear after set: rdy/data got %b/%02h, required 0/c3", rdy, rx_data);
                end
            end
        join
    endtask

    task automatic test_frame_err();
        logic exp_rdy, exp_err;
`ifdef UART_RX_FRAME_ERR_EN
        exp_rdy = 1'b0;
        exp_err = 1'b1;
`else
        exp_rdy = 1'b1;
        exp_err = 1'b0;
`endif
        clear_caps();
        send_frame(8'h3C, 1'b0);
        wait_caps(1, 50, "bad stop");
        check_cap(0, 8'h3C, exp_rdy, exp_err, "bad stop");
        repeat (4) @(negedge clk);
        send_frame(8'h11, 1'b1);
        wait_caps(2, 50, "after bad stop");
        check_cap(1, 8'h11, 1'b1, 1'b0, "after bad stop");
    endtask

    task automatic test_overrun();
        logic [7:0] vals[3];
        vals = '{8'h12, 8'h34, 8'h56};
        clear_caps();
        for (int i = 0; i < 3; i++) send_frame(vals[i], 1'b1);
        wait_caps(3, 50, "overrun");
        for (int i = 0; i < 3; i++) check_cap(i, vals[i], 1'b1, 1'b0, "overrun");
        repeat (50) @(negedge clk);
        checks++;
        if (rdy !== 1'b1 || rx_data !== 8'h56) begin
            failures++;
            $display("FAIL overrun hold: rdy/data got %b/%02h, required 1/56", rdy, rx_data);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] bits;
        bits = {1'b1, 8'h81, 1'b0};
        clear_caps();
        for (int k = 0; k < 4; k++) begin
            rx_line = bits[k];
            repeat (B) @(negedge clk);
        end
        rx_line = bits[4];
        repeat (H) @(negedge clk);
        rst_n   = 1'b0;
        rx_line = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (rx_data !== 8'h00 || rdy !== 1'b0 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL reset mid frame: data/rdy/err got %02h/%b/%b, required 00/0/0",
                     rx_data, rdy, frame_err);
        end
        rst_n = 1'b1;
        repeat (12 * B) @(negedge clk);
        checks++;
        if (cap_data.size() != 0 || rdy !== 1'b0) begin
            failures++;
            $display("FAIL no frame after reset: captures/rdy got %0d/%b, required 0/0",
                     cap_data.size(), rdy);
        end
        send_frame(8'h7E, 1'b1);
        wait_caps(1, 50, "after reset");
        check_cap(0, 8'h7E, 1'b1, 1'b0, "after reset");
    endtask

    task automatic test_random_bytes();
        logic [7:0] exp_q[$];
        bit done;
        done = 1'b0;
        clear_caps();
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    logic [7:0] d;
                    d = 8'($urandom);
                    exp_q.push_back(d);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    send_frame(d, 1'b1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    clr_rdy = ($urandom_range(0, 3) == 0);
                end
                clr_rdy = 1'b0;
            end
        join
        wait_caps(200, 50, "random");
        for (int i = 0; i < 200; i++) check_cap(i, exp_q[i], 1'b1, 1'b0, "random");
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_set_clr_priority();
        test_frame_err();
        test_overrun();
        test_reset_mid_frame();
        test_random_bytes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
